// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG initiator that walks a target TAP from Run-Test/Idle through Shift-IR/DR and back.
// Optional JTAG_MASTER_AUTO_RESET_EN: after rst deasserts, run a silent TAP reset sequence before accepting commands.
module jtag_master #(
    parameter int CLOCK_DIVIDER    = 4,
    parameter int MAX_SHIFT_LENGTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_type,
    input  logic [5:0]                  cmd_length,
    input  logic [MAX_SHIFT_LENGTH-1:0] cmd_data,
    output logic                        rsp_valid,
    output logic [MAX_SHIFT_LENGTH-1:0] rsp_data,
    output logic                        busy,
    output logic                        jtag_tck,
    output logic                        jtag_tms,
    output logic                        jtag_tdi,
    input  logic                        jtag_tdo
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SHIFT, POSTAMBLE, DONE} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLOCK_DIVIDER - 1);
    localparam logic [6:0] MAX_LEN   = 7'(MAX_SHIFT_LENGTH);
    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_DR    = 2'd2;
    localparam logic [1:0] CMD_IDLE  = 2'd3;
    // TMS walks from Run-Test/Idle, bit 0 first.
    localparam logic [5:0] SEQ_RESET = 6'b011111;
    localparam logic [5:0] SEQ_IR    = 6'b000011;
    localparam logic [5:0] SEQ_DR    = 6'b000001;

    state_t                      state;
    logic [7:0]                  divCnt;
    logic [5:0]                  preSeq;
    logic [2:0]                  preLeft;
    logic [5:0]                  bitLeft;
    logic [5:0]                  shLen;
    logic [1:0]                  postLeft;
    logic                        isScan;
    logic                        silent;
    logic [MAX_SHIFT_LENGTH-1:0] dataSh;
    logic [MAX_SHIFT_LENGTH-1:0] capSh;
    logic                        accept;
    logic                        tckEdge;
    logic [5:0]                  clampLen;

    // Handshake, divider terminal count and clamped scan length.
    always_comb begin
        accept  = cmd_valid && cmd_ready;
        tckEdge = (divCnt == DIV_LAST);
        if ({1'b0, cmd_length} > MAX_LEN) begin
            clampLen = MAX_LEN[5:0];
        end else begin
            clampLen = cmd_length;
        end
    end

    // Command sequencer, TCK divider, TMS/TDI drive and TDO capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divCnt    <= 8'd0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            dataSh    <= '0;
            capSh     <= '0;
            bitLeft   <= 6'd0;
            shLen     <= 6'd0;
            postLeft  <= 2'd0;
            isScan    <= 1'b0;
`ifdef JTAG_MASTER_AUTO_RESET_EN
            state     <= PREAMBLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            preSeq    <= SEQ_RESET;
            preLeft   <= 3'd6;
            silent    <= 1'b1;
`else
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            preSeq    <= 6'd0;
            preLeft   <= 3'd0;
            silent    <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        divCnt    <= 8'd0;
                        jtag_tck  <= 1'b0;
                        jtag_tdi  <= 1'b0;
                        silent    <= 1'b0;
                        dataSh    <= cmd_data;
                        capSh     <= '0;
                        shLen     <= clampLen;
                        case (cmd_type)
                            CMD_RESET: begin
                                state    <= PREAMBLE;
                                preSeq   <= SEQ_RESET;
                                preLeft  <= 3'd6;
                                jtag_tms <= 1'b1;
                                isScan   <= 1'b0;
                            end
                            CMD_IR, CMD_DR: begin
                                isScan <= 1'b1;
                                if (cmd_length == 6'd0) begin
                                    state     <= DONE;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    state    <= PREAMBLE;
                                    preSeq   <= (cmd_type == CMD_IR) ? SEQ_IR : SEQ_DR;
                                    preLeft  <= (cmd_type == CMD_IR) ? 3'd4 : 3'd3;
                                    jtag_tms <= 1'b1;
                                end
                            end
                            CMD_IDLE: begin
                                isScan  <= 1'b0;
                                bitLeft <= cmd_length;
                                if (cmd_length == 6'd0) begin
                                    state     <= DONE;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    state    <= SHIFT;
                                    jtag_tms <= 1'b0;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else begin
                        state <= IDLE;
                    end
                end
                PREAMBLE, SHIFT, POSTAMBLE: begin
                    if (!tckEdge) begin
                        divCnt <= divCnt + 8'd1;
                    end else begin
                        divCnt   <= 8'd0;
                        jtag_tck <= !jtag_tck;
                        if (!jtag_tck) begin
                            if (state == SHIFT && isScan) begin
                                capSh <= {jtag_tdo, capSh[MAX_SHIFT_LENGTH-1:1]};
                            end else begin
                                capSh <= capSh;
                            end
                        end else begin
                            // Falling TCK edge: step to the next TMS/TDI bit.
                            case (state)
                                PREAMBLE: begin
                                    if (preLeft == 3'd1) begin
                                        if (isScan) begin
                                            state    <= SHIFT;
                                            bitLeft  <= shLen;
                                            jtag_tms <= (shLen == 6'd1);
                                            jtag_tdi <= dataSh[0];
                                        end else begin
                                            state     <= DONE;
                                            rsp_valid <= !silent;
                                            rsp_data  <= '0;
                                        end
                                    end else begin
                                        preLeft  <= preLeft - 3'd1;
                                        preSeq   <= preSeq >> 1;
                                        jtag_tms <= preSeq[1];
                                    end
                                end
                                SHIFT: begin
                                    if (bitLeft == 6'd1) begin
                                        jtag_tdi <= 1'b0;
                                        if (isScan) begin
                                            state    <= POSTAMBLE;
                                            postLeft <= 2'd2;
                                            jtag_tms <= 1'b1;
                                        end else begin
                                            state     <= DONE;
                                            rsp_valid <= 1'b1;
                                            rsp_data  <= '0;
                                        end
                                    end else begin
                                        bitLeft  <= bitLeft - 6'd1;
                                        jtag_tms <= isScan && (bitLeft == 6'd2);
                                        jtag_tdi <= isScan && dataSh[1];
                                        dataSh   <= dataSh >> 1;
                                    end
                                end
                                POSTAMBLE: begin
                                    if (postLeft == 2'd1) begin
                                        state     <= DONE;
                                        rsp_valid <= 1'b1;
                                        // Captured bits enter at the MSB; right-align them.
                                        rsp_data  <= capSh >> (MAX_LEN - {1'b0, shLen});
                                    end else begin
                                        postLeft <= 2'd1;
                                        jtag_tms <= 1'b0;
                                    end
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    silent    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: table-driven and randomized checks of jtag_master against a TMS/TDI reference model,
// a loopback target and a behavioural 16-state TAP holding IDCODE/USERCODE.
module tb_jtag_master;
    localparam int CLKDIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'd0;
    logic [5:0]  cmd_length = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        jtag_tck;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;

    jtag_master #(.CLOCK_DIVIDER(CLKDIV), .MAX_SHIFT_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Behavioural target TAP (IR 5 bits, reset instruction IDCODE).
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    localparam logic [4:0]  IR_IDCODE    = 5'b00100;
    localparam logic [4:0]  IR_USERCODE  = 5'b00011;
    localparam logic [31:0] IDCODE_VAL   = {4'd1, 16'hBEEF, 11'h23B, 1'b1};
    localparam logic [31:0] USERCODE_VAL = 32'h12345678;

    tap_t        tap = TLR;
    logic [4:0]  ir = IR_IDCODE;
    logic [4:0]  irSh = 5'd0;
    logic [31:0] drSh = 32'd0;
    logic        tapTdo = 1'b0;
    bit          tapMode = 1'b0;

    function automatic tap_t tapNext(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge jtag_tck) begin
        case (tap)
            TLR:   ir <= IR_IDCODE;
            CAPDR: drSh <= (ir == IR_IDCODE) ? IDCODE_VAL : (ir == IR_USERCODE) ? USERCODE_VAL : 32'd0;
            SHDR:  drSh <= (ir == IR_IDCODE || ir == IR_USERCODE) ? {jtag_tdi, drSh[31:1]} : {31'd0, jtag_tdi};
            CAPIR: irSh <= 5'b00001;
            SHIR:  irSh <= {jtag_tdi, irSh[4:1]};
            UPIR:  ir <= irSh;
            default: ;
        endcase
        tap <= tapNext(tap, jtag_tms);
    end

    always @(negedge jtag_tck) tapTdo <= (tap == SHDR) ? drSh[0] : (tap == SHIR) ? irSh[0] : 1'b0;

    assign jtag_tdo = tapMode ? tapTdo : jtag_tdi;

    // Per-TCK-period record of what the master drove.
    bit obsTms[$];
    bit obsTdi[$];
    always @(posedge jtag_tck) begin
        obsTms.push_back(jtag_tms);
        obsTdi.push_back(jtag_tdi);
    end

    // Reference model: expected TMS/TDI per TCK period and loopback response.
    bit          expTms[$];
    bit          expTdi[$];
    logic [31:0] expRspM;

    task automatic push(input bit m, input bit d);
        expTms.push_back(m);
        expTdi.push_back(d);
    endtask

    task automatic buildExp(input logic [1:0] t, input int len, input logic [31:0] d);
        int n;
        logic [63:0] mask;
        expTms.delete();
        expTdi.delete();
        n = (t == 2'd1 || t == 2'd2) ? ((len > 32) ? 32 : len) : len;
        mask = (64'd1 << n) - 64'd1;
        expRspM = 32'd0;
        if (t == 2'd0) begin
            for (int i = 0; i < 6; i++) push(i < 5, 1'b0);
        end else if (t == 2'd3) begin
            for (int i = 0; i < n; i++) push(1'b0, 1'b0);
        end else if (n > 0) begin
            push(1'b1, 1'b0);
            if (t == 2'd1) push(1'b1, 1'b0);
            push(1'b0, 1'b0);
            push(1'b0, 1'b0);
            for (int i = 0; i < n; i++) push(i == n - 1, d[i]);
            push(1'b1, 1'b0);
            push(1'b0, 1'b0);
            expRspM = d & mask[31:0];
        end
    endtask

    function automatic logic [63:0] packQ(input bit q[$]);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic doCmd(input logic [1:0] t, input logic [5:0] len, input logic [31:0] d,
                         output logic [31:0] rsp, output int lat);
        int guard = 0;
        bit sawValid = 1'b0;
        @(negedge clk);
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", {63'd0, cmd_ready}, 64'd1);
        obsTms.delete();
        obsTdi.delete();
        cmd_valid = 1'b1;
        cmd_type = t;
        cmd_length = len;
        cmd_data = d;
        @(posedge clk);
        #1;
        // Keep cmd_valid asserted with junk fields: must be ignored while busy.
        cmd_type = 2'($urandom);
        cmd_length = 6'($urandom);
        cmd_data = $urandom;
        lat = 0;
        while (!sawValid && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) sawValid = 1'b1;
        end
        cmd_valid = 1'b0;
        rsp = rsp_data;
        @(negedge clk);
        chk("after_done", {61'd0, cmd_ready, busy, rsp_valid}, 64'd4);
        chk("rsp_hold", rsp_data, rsp);
    endtask

    task automatic runVec(input string nm, input logic [1:0] t, input logic [5:0] len, input logic [31:0] d,
                          input bit tm, input logic [31:0] expRsp, input int expPer);
        logic [31:0] rsp;
        int lat;
        tapMode = tm;
        buildExp(t, len, d);
        doCmd(t, len, d, rsp, lat);
        chk({nm, "_rsp"}, rsp, expRsp);
        chk({nm, "_latency"}, lat, expPer * 2 * CLKDIV + 1);
        chk({nm, "_tck_count"}, obsTms.size(), expPer);
        chk({nm, "_tms"}, packQ(obsTms), packQ(expTms));
        chk({nm, "_tdi"}, packQ(obsTdi), packQ(expTdi));
        if (tm) chk({nm, "_tap_rti"}, 64'(tap), 64'(RTI));
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  t;
        logic [5:0]  len;
        logic [31:0] d;
        bit          tm;
        logic [31:0] expRsp;
        int          expPer;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0] rt;
        logic [5:0] rl;
        bit seenRsp;

        vecs[0]  = '{"reset_loop",   2'd0, 6'd0,  32'h0,        1'b0, 32'h0,        6};
        vecs[1]  = '{"dr8_loop",     2'd2, 6'd8,  32'hA5,       1'b0, 32'hA5,       13};
        vecs[2]  = '{"reset_tap",    2'd0, 6'd0,  32'h0,        1'b1, 32'h0,        6};
        vecs[3]  = '{"ir_idcode",    2'd1, 6'd5,  32'h4,        1'b1, 32'h1,        11};
        vecs[4]  = '{"dr_idcode",    2'd2, 6'd32, 32'h0,        1'b1, 32'h1BEEF477, 37};
        vecs[5]  = '{"ir_usercode",  2'd1, 6'd5,  32'h3,        1'b1, 32'h1,        11};
        vecs[6]  = '{"dr_usercode",  2'd2, 6'd32, 32'h0,        1'b1, 32'h12345678, 37};
        vecs[7]  = '{"dr_len0",      2'd2, 6'd0,  32'hFFFF,     1'b0, 32'h0,        0};
        vecs[8]  = '{"dr_len40",     2'd2, 6'd40, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 37};
        vecs[9]  = '{"idle3",        2'd3, 6'd3,  32'hFF,       1'b0, 32'h0,        3};
        vecs[10] = '{"ir_len0",      2'd1, 6'd0,  32'h1,        1'b0, 32'h0,        0};
        vecs[11] = '{"idle_len0",    2'd3, 6'd0,  32'h1,        1'b0, 32'h0,        0};
        vecs[12] = '{"ir_len1",      2'd1, 6'd1,  32'h1,        1'b0, 32'h1,        7};

        // Reset values while rst is held.
        @(negedge clk);
        @(negedge clk);
`ifdef JTAG_MASTER_AUTO_RESET_EN
        chk("reset_outputs", {58'd0, jtag_tck, jtag_tms, jtag_tdi, rsp_valid, busy, cmd_ready}, 64'b010010);
`else
        chk("reset_outputs", {58'd0, jtag_tck, jtag_tms, jtag_tdi, rsp_valid, busy, cmd_ready}, 64'b010001);
`endif
        chk("reset_rsp_data", rsp_data, 32'd0);
        obsTms.delete();
        obsTdi.delete();
        rst = 1'b0;
        @(negedge clk);
`ifdef JTAG_MASTER_AUTO_RESET_EN
        seenRsp = 1'b0;
        for (int i = 0; i < 200 && !cmd_ready; i++) begin
            @(negedge clk);
            if (rsp_valid) seenRsp = 1'b1;
        end
        chk("auto_reset_ready", {63'd0, cmd_ready}, 64'd1);
        chk("auto_reset_tck_count", obsTms.size(), 6);
        chk("auto_reset_tms", packQ(obsTms), 64'b011111);
        chk("auto_reset_no_rsp", {63'd0, seenRsp}, 64'd0);
`else
        chk("ready_after_reset", {62'd0, cmd_ready, busy}, 64'b10);
`endif

        foreach (vecs[i]) runVec(vecs[i].nm, vecs[i].t, vecs[i].len, vecs[i].d, vecs[i].tm,
                                 vecs[i].expRsp, vecs[i].expPer);

        // Randomized commands in loopback against the reference model.
        for (int k = 0; k < 40; k++) begin
            rt = 2'($urandom_range(0, 3));
            rl = (rt == 2'd3) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 40));
            rd = $urandom;
            buildExp(rt, int'(rl), rd);
            runVec("rand", rt, rl, rd, 1'b0, expRspM, expTms.size());
        end

        // Abort: rst asserted during the 10th shift TCK of a 32-bit DR scan.
        tapMode = 1'b1;
        @(negedge clk);
        obsTms.delete();
        obsTdi.delete();
        cmd_valid = 1'b1;
        cmd_type = 2'd2;
        cmd_length = 6'd32;
        cmd_data = 32'h0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 500 && obsTms.size() < 13; i++) @(negedge clk);
        chk("abort_reached_shift10", {63'd0, jtag_tck}, 64'd1);
        rst = 1'b1;
        #1;
`ifdef JTAG_MASTER_AUTO_RESET_EN
        chk("abort_outputs", {61'd0, jtag_tck, jtag_tms, rsp_valid}, 64'b010);
`else
        chk("abort_outputs", {60'd0, jtag_tck, jtag_tms, busy, rsp_valid}, 64'b0100);
`endif
        seenRsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seenRsp = 1'b1;
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seenRsp = 1'b1;
        end
        chk("abort_no_rsp", {63'd0, seenRsp}, 64'd0);
        runVec("post_abort_reset", 2'd0, 6'd0, 32'h0, 1'b1, 32'h0, 6);
        runVec("post_abort_idcode", 2'd2, 6'd32, 32'h0, 1'b1, 32'h1BEEF477, 37);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- JTAG initiator: drives TCK/TMS/TDI, samples TDO, and walks a target TAP through the standard 16-state controller.
- Used on-chip and in benches to reach the core's JTAG TAP (IDCODE/USERCODE/SAMPLE management access) from a simple command/response interface.
- Accepts one command at a time: TAP reset, IR scan, DR scan or idle clocks. Returns captured TDO bits per command.

Parameters:
- CLOCK_DIVIDER, 4: clk cycles per TCK half-period; legal range 2..255.
- MAX_SHIFT_LENGTH, 32: maximum IR/DR scan length in bits; also the width of cmd_data and rsp_data.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  block idle and able to accept a command
- cmd_type  input  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks
- cmd_length  input  6  scan bit count (IR/DR) or TCK count (idle)
- cmd_data  input  32  TDI data, LSB shifted first
- rsp_valid  output  1  one-cycle pulse when a command completes
- rsp_data  output  32  captured TDO bits, LSB first, right-aligned
- busy  output  1  command in progress
- jtag_tck  output  1  test clock
- jtag_tms  output  1  test mode select
- jtag_tdi  output  1  test data to target
- jtag_tdo  input  1  test data from target

Behaviour:
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, divider=0, FSM=IDLE.
- Reset mid-command aborts immediately with no response. The target TAP state is then undefined, so host software issues a TAP reset command.
- Handshake: a command is accepted on the cycle with cmd_valid && cmd_ready. Fields are latched on accept; cmd_ready=0 and busy=1 until completion.
- TCK generation: each TCK period is a low phase of CLOCK_DIVIDER clk, then a high phase of CLOCK_DIVIDER clk. jtag_tck is registered.
- TMS/TDI change only at TCK falling edges; the first bit is driven on the accept cycle.
- jtag_tdo is sampled on the clk cycle that raises TCK.
- FSM states:
  - IDLE.
  - PREAMBLE (TMS walk to the Shift state).
  - SHIFT.
  - POSTAMBLE (Exit1 -> Update -> Run-Test/Idle).
  - DONE: one cycle; pulses rsp_valid, then returns to IDLE with cmd_ready=1 on the next cycle.
- Every command assumes the target starts in Run-Test/Idle and leaves it in Run-Test/Idle.
- TMS sequences per command type:
  - TAP reset: TMS 1,1,1,1,1,0 (6 TCK); rsp_data=0.
  - DR scan: TMS 1,0,0, then N shift TCKs with TMS=0 except the last bit TMS=1, then TMS 1,0.
  - IR scan: TMS 1,1,0,0, then the same shift and postamble as DR scan.
  - Idle clocks: cmd_length TCKs with TMS=0, TDI=0; rsp_data=0.
- Scan TDI: bit i of cmd_data is driven during the i-th shift TCK (i=0 first).
- Scan TDO capture: the TDO sampled at the i-th shift rising edge goes to rsp_data[i]. Bits at and above N are 0.
- TDI is 0 outside SHIFT.
- Length rules:
  - cmd_length=0 for IR/DR/idle: no TCK activity; DONE follows the accept cycle directly with rsp_data=0.
  - cmd_length>MAX_SHIFT_LENGTH for IR/DR: clamped to MAX_SHIFT_LENGTH. Idle clocks are not clamped (max 63).
- Total TCK periods: DR = N+5, IR = N+6.
- rsp_data holds its value until the next DONE.
- A cmd_valid held during busy is ignored until cmd_ready returns.

Optional Feature:
- Macro: JTAG_MASTER_AUTO_RESET_EN.
- Defined: after rst deasserts, the block runs the TAP reset sequence (TMS 1,1,1,1,1,0) automatically.
  - cmd_ready stays 0 and busy stays 1 until it finishes.
  - No rsp_valid pulse is produced.
- Undefined: cmd_ready=1 immediately after reset; the TAP is not touched until a command arrives.

Test Plan:
- CLOCK_DIVIDER=2, TAP reset command -> 6 TCK periods of 4 clk each; TMS per period 1,1,1,1,1,0; rsp_valid pulses once with rsp_data=0; cmd_ready returns the next cycle.
- Loopback (jtag_tdo tied to jtag_tdi), DR scan length 8, data 0xA5 -> rsp_data=0x000000A5; 13 TCK periods; TMS=1 on exactly the 8th shift TCK.
- Against the core JTAG TAP (coreID=0x12345678, versionID=1, partID=0xBEEF, manufacturerID=0x23B):
  - IR scan length 5, data 0b00100 -> completes.
  - DR scan length 32 -> rsp_data=0x1BEEF477.
  - IR 0b00011 then DR 32 -> rsp_data=0x12345678.
- DR scan with cmd_length=0 -> no TCK edges; rsp_valid one cycle after accept; rsp_data=0.
  - cmd_length=40 -> exactly 32 shift TCKs.
- Assert rst during the 10th shift TCK of a 32-bit DR scan -> same cycle jtag_tck=0, jtag_tms=1, busy=0, no rsp_valid.
- With JTAG_MASTER_AUTO_RESET_EN, release rst -> 6 TCKs with TMS 1,1,1,1,1,0 before cmd_ready=1; without it, cmd_ready=1 on the first cycle after reset.
